// File: rtl/hdr_tgt_engine_sched_if.sv
// Handshake bundle between the HDR-DDR target engine sequencer and its
// surroundings (main controller, RX deserializer, CCC and DDR handlers).
//   slave  : the sequencer side (consumes i_*, drives o_*)
//   master : the environment side (drives i_*, consumes o_*)
interface hdr_tgt_engine_sched_if;
    logic        i_engine_en;
    logic        i_rx_mode_done;
    logic [15:0] i_rx_cmd_word;
    logic        i_rx_error;
    logic        i_ccc_done;
    logic        i_ddr_done;
    logic        i_restart_done;
    logic        i_exit_done;
    logic        o_rx_en;
    logic [2:0]  o_rx_mode;
    logic        o_ccc_en;
    logic        o_ddr_en;
    logic        o_RnW;
    logic [6:0]  o_cmd_code;
    logic        o_engine_done;
    logic        o_err;

    modport slave (
        input  i_engine_en, i_rx_mode_done, i_rx_cmd_word, i_rx_error,
               i_ccc_done, i_ddr_done, i_restart_done, i_exit_done,
        output o_rx_en, o_rx_mode, o_ccc_en, o_ddr_en, o_RnW, o_cmd_code,
               o_engine_done, o_err
    );

    modport master (
        output i_engine_en, i_rx_mode_done, i_rx_cmd_word, i_rx_error,
               i_ccc_done, i_ddr_done, i_restart_done, i_exit_done,
        input  o_rx_en, o_rx_mode, o_ccc_en, o_ddr_en, o_RnW, o_cmd_code,
               o_engine_done, o_err
    );
endinterface

// File: rtl/hdr_tgt_engine_sched.sv
// Target-side HDR-DDR engine sequencer. Walks the RX path through preamble
// and command word, decodes the command, dispatches the frame to the CCC
// handler (broadcast 7'h7E) or private DDR handler (own address), watches
// handler completion with a watchdog, and follows HDR Restart / HDR Exit.
// Ports:
//   i_sys_clk  : system clock, rising edge
//   i_sys_rst  : synchronous active-high reset
//   eng        : handshake bundle (slave side); all o_* outputs registered
module hdr_tgt_engine_sched #(
    parameter logic [6:0]  TGT_ADDR    = 7'h52,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst,
    hdr_tgt_engine_sched_if.slave  eng
);
    localparam logic [6:0]       BCAST_ADDR  = 7'h7E;
    localparam logic [2:0]       RX_MODE_PRE = 3'd0;
    localparam logic [2:0]       RX_MODE_CMD = 3'd1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_CMD, S_DISP, S_CCC, S_DDR, S_SKIP, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic [6:0]         addr_q, addr_d;
    logic               rnw_q, rnw_d;
    logic [6:0]         code_q, code_d;
    logic               rx_en_q, rx_en_d;
    logic [2:0]         rx_mode_q, rx_mode_d;
    logic               ccc_en_q, ccc_en_d;
    logic               ddr_en_q, ddr_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               in_session_c;
    logic               parity_ok_c;
    logic               timeout_c;

    // Bus-level Restart/Exit only matter once a session is running
    assign in_session_c = (state_q != S_IDLE) && (state_q != S_DONE);
    // Odd parity over the whole word: bit0 = ~^cmd[15:1]
    assign parity_ok_c  = (eng.i_rx_cmd_word[0] == ~^eng.i_rx_cmd_word[15:1]);
    assign timeout_c    = (cnt_q == CNT_LAST);

    // Next-state, latches, watchdog and next-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        // A low level arms the next start; a held-high level never re-arms
        armed_d = armed_q | ~eng.i_engine_en;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        code_d  = code_q;
        err_d   = 1'b0;

        if (in_session_c && eng.i_exit_done) begin
            state_d = S_DONE;
        end else if (in_session_c && eng.i_restart_done) begin
            state_d = S_PRE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (eng.i_engine_en && armed_q) begin
                        state_d = S_PRE;
                        armed_d = 1'b0;
                    end
                end
                S_PRE: begin
                    if (eng.i_rx_mode_done) begin
                        state_d = eng.i_rx_error ? S_SKIP : S_CMD;
                    end
                end
                S_CMD: begin
                    if (eng.i_rx_mode_done) begin
                        rnw_d  = eng.i_rx_cmd_word[15];
                        code_d = eng.i_rx_cmd_word[14:8];
                        addr_d = eng.i_rx_cmd_word[7:1];
                        if (eng.i_rx_error || !parity_ok_c) begin
                            state_d = S_SKIP;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_DISP;
                        end
                    end
                end
                S_DISP: begin
                    if (addr_q == BCAST_ADDR) begin
                        state_d = S_CCC;
                    end else if (addr_q == TGT_ADDR) begin
                        state_d = S_DDR;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
                S_CCC: begin
                    if (eng.i_ccc_done) begin
                        state_d = S_SKIP;
                    end else if (timeout_c) begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end
                S_DDR: begin
                    if (eng.i_ddr_done) begin
                        state_d = S_SKIP;
                    end else if (timeout_c) begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end
                S_SKIP: begin
                    // Parked until the bus signals Restart or Exit
                    state_d = S_SKIP;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Watchdog runs only while staying in a handler state; saturates
        if ((state_d == state_q) && ((state_q == S_CCC) || (state_q == S_DDR))) begin
            cnt_d = timeout_c ? cnt_q : cnt_q + CNT_W'(1);
        end

        // Outputs follow the state being entered so they change with it
        rx_en_d   = (state_d == S_PRE) || (state_d == S_CMD);
        rx_mode_d = (state_d == S_CMD) ? RX_MODE_CMD : RX_MODE_PRE;
        ccc_en_d  = (state_d == S_CCC);
        ddr_en_d  = (state_d == S_DDR);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            addr_q    <= '0;
            rnw_q     <= 1'b0;
            code_q    <= '0;
            rx_en_q   <= 1'b0;
            rx_mode_q <= '0;
            ccc_en_q  <= 1'b0;
            ddr_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            addr_q    <= addr_d;
            rnw_q     <= rnw_d;
            code_q    <= code_d;
            rx_en_q   <= rx_en_d;
            rx_mode_q <= rx_mode_d;
            ccc_en_q  <= ccc_en_d;
            ddr_en_q  <= ddr_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign eng.o_rx_en       = rx_en_q;
    assign eng.o_rx_mode     = rx_mode_q;
    assign eng.o_ccc_en      = ccc_en_q;
    assign eng.o_ddr_en      = ddr_en_q;
    assign eng.o_RnW         = rnw_q;
    assign eng.o_cmd_code    = code_q;
    assign eng.o_engine_done = done_q;
    assign eng.o_err         = err_q;
endmodule

// File: tb/tb_hdr_tgt_engine_sched.sv
// Scoreboard bench for hdr_tgt_engine_sched. The driver keeps a session-level
// model (which phase of the HDR frame the target is in) and pushes the output
// snapshot it expects, tagged with the cycle it must appear in. The monitor
// samples on the falling edge and pops an expectation whenever the outputs
// change, a pulse is high, or a forced check cycle is reached.
module tb_hdr_tgt_engine_sched;
    localparam int unsigned TIMEOUT = 1024;

    localparam int P_IDLE = 0;
    localparam int P_PRE  = 1;
    localparam int P_CMD  = 2;
    localparam int P_CCC  = 3;
    localparam int P_DDR  = 4;
    localparam int P_SKIP = 5;

    typedef struct packed {
        logic       rx_en;
        logic [2:0] mode;
        logic       ccc;
        logic       ddr;
        logic       rnw;
        logic [6:0] code;
        logic       err;
        logic       done;
    } lv_t;

    typedef struct {
        int  cyc;
        lv_t v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hdr_tgt_engine_sched_if bus();

    hdr_tgt_engine_sched #(
        .TGT_ADDR   (7'h52),
        .TIMEOUT_CYC(TIMEOUT),
        .CNT_W      (11)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst),
        .eng      (bus)
    );

    exp_t       expq[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         chk_cyc     = -1;
    bit         mon_on      = 1'b0;

    // Session model state
    int         phase = P_IDLE;
    lv_t        m_cur = '0;
    logic       m_rnw = 1'b0;
    logic [6:0] m_code = '0;
    int         h_cyc = 0;

    function automatic lv_t sample();
        lv_t s;
        s.rx_en = bus.o_rx_en;
        s.mode  = bus.o_rx_mode;
        s.ccc   = bus.o_ccc_en;
        s.ddr   = bus.o_ddr_en;
        s.rnw   = bus.o_RnW;
        s.code  = bus.o_cmd_code;
        s.err   = bus.o_err;
        s.done  = bus.o_engine_done;
        return s;
    endfunction

    function automatic lv_t lvl(input lv_t x);
        lv_t y;
        y = x;
        y.err  = 1'b0;
        y.done = 1'b0;
        return y;
    endfunction

    task automatic monitor();
        lv_t  prev, cur;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = sample();
            if (mon_on) begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    e = expq.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_event cyc=%0d got=none required=%h at cyc %0d",
                             cyc, e.v, e.cyc);
                end
                if (cur.err || cur.done || (lvl(cur) != lvl(prev)) || (cyc == chk_cyc)) begin
                    vectors++;
                    if (expq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_event cyc=%0d got=%h required=no change",
                                 cyc, cur);
                    end else begin
                        e = expq.pop_front();
                        if (e.cyc != cyc || e.v !== cur) begin
                            miscompares++;
                            $display("FAIL outputs cyc=%0d got=%h required=%h at cyc %0d",
                                     cyc, cur, e.v, e.cyc);
                        end
                    end
                end
            end
            prev = cur;
        end
    endtask

    // Record what the outputs must look like in cycle c
    function automatic void expect_lv(input int c, input logic rx_en, input logic [2:0] mode,
                                      input logic ccc, input logic ddr, input logic err,
                                      input logic done, input bit force_chk);
        lv_t  n;
        exp_t e;
        n       = '0;
        n.rx_en = rx_en;
        n.mode  = mode;
        n.ccc   = ccc;
        n.ddr   = ddr;
        n.rnw   = m_rnw;
        n.code  = m_code;
        if (n != m_cur || err || done || force_chk) begin
            e.cyc    = c;
            e.v      = n;
            e.v.err  = err;
            e.v.done = done;
            expq.push_back(e);
            if (force_chk) chk_cyc = c;
        end
        m_cur = n;
    endfunction

    function automatic logic [15:0] mk_cmd(input logic rnw, input logic [6:0] code,
                                           input logic [6:0] addr, input bit good);
        logic [15:0] w;
        w = {rnw, code, addr, 1'b0};
        if (($countones(w) % 2) == 0) w[0] = 1'b1;
        if (!good) w[0] = ~w[0];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Apply one cycle of input pulses and predict the reaction
    task automatic drive(input logic md, input logic rxe, input logic [15:0] w,
                         input logic cd, input logic dd, input logic rs, input logic ex);
        int         c;
        bit         disp;
        logic [6:0] a;
        c    = cyc;
        disp = 1'b0;
        bus.i_rx_mode_done = md;
        bus.i_rx_error     = rxe;
        bus.i_rx_cmd_word  = w;
        bus.i_ccc_done     = cd;
        bus.i_ddr_done     = dd;
        bus.i_restart_done = rs;
        bus.i_exit_done    = ex;
        if (phase == P_IDLE) begin
            // outside a session nothing reacts
        end else if (ex) begin
            expect_lv(c + 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            phase = P_IDLE;
        end else if (rs) begin
            expect_lv(c + 1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            phase = P_PRE;
        end else begin
            case (phase)
                P_PRE: if (md) begin
                    if (rxe) begin
                        expect_lv(c + 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                        phase = P_SKIP;
                    end else begin
                        expect_lv(c + 1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                        phase = P_CMD;
                    end
                end
                P_CMD: if (md) begin
                    m_rnw  = w[15];
                    m_code = w[14:8];
                    a      = w[7:1];
                    if (rxe || ($countones(w) % 2) == 0) begin
                        expect_lv(c + 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                        phase = P_SKIP;
                    end else begin
                        expect_lv(c + 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                        disp = 1'b1;
                        if (a == 7'h7E) begin
                            expect_lv(c + 2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                            phase = P_CCC;
                            h_cyc = c + 2;
                        end else if (a == 7'h52) begin
                            expect_lv(c + 2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                            phase = P_DDR;
                            h_cyc = c + 2;
                        end else begin
                            phase = P_SKIP;
                        end
                    end
                end
                P_CCC: if (cd) begin
                    expect_lv(c + 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    phase = P_SKIP;
                end
                P_DDR: if (dd) begin
                    expect_lv(c + 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    phase = P_SKIP;
                end
                default: ;
            endcase
        end
        step();
        bus.i_rx_mode_done = 1'b0;
        bus.i_rx_error     = 1'b0;
        bus.i_ccc_done     = 1'b0;
        bus.i_ddr_done     = 1'b0;
        bus.i_restart_done = 1'b0;
        bus.i_exit_done    = 1'b0;
        if (disp) step();
    endtask

    task automatic pre(input logic rxe);
        drive(1'b1, rxe, 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cmd(input logic [15:0] w, input logic rxe);
        drive(1'b1, rxe, w, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_session();
        int c;
        bus.i_engine_en = 1'b0;
        step();
        bus.i_engine_en = 1'b1;
        c = cyc;
        expect_lv(c + 1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        phase = P_PRE;
        step();
    endtask

    task automatic do_reset();
        int c;
        c = cyc;
        rst    = 1'b1;
        m_rnw  = 1'b0;
        m_code = '0;
        expect_lv(c + 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        phase = P_IDLE;
        step();
        rst = 1'b0;
    endtask

    // Let the dispatched handler run silent until the watchdog fires
    task automatic wait_timeout();
        expect_lv(h_cyc + int'(TIMEOUT), 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        phase = P_SKIP;
        while (cyc < h_cyc + int'(TIMEOUT)) step();
    endtask

    task automatic rand_session();
        int unsigned r;
        int unsigned r2;
        logic [6:0]  a;
        start_session();
        if ($urandom_range(0, 3) == 0) bus.i_engine_en = 1'b0;
        for (int k = 0; k < 8 && phase != P_IDLE; k++) begin
            idle(int'($urandom_range(0, 3)));
            r = $urandom_range(0, 99);
            case (phase)
                P_PRE: begin
                    if (r < 8)       drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
                    else if (r < 12) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
                    else             pre(r < 25);
                end
                P_CMD: begin
                    if (r < 6) begin
                        drive(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
                    end else begin
                        r2 = $urandom_range(0, 2);
                        a  = (r2 == 0) ? 7'h7E : (r2 == 1) ? 7'h52 : 7'($urandom_range(0, 127));
                        cmd(mk_cmd(1'($urandom), 7'($urandom), a, $urandom_range(0, 99) < 85),
                            $urandom_range(0, 99) < 10);
                    end
                end
                P_CCC, P_DDR: begin
                    if (r < 10) begin
                        wait_timeout();
                    end else if (r < 25) begin
                        // done from the handler that was not selected
                        drive(1'b0, 1'b0, 16'h0, phase == P_DDR, phase == P_CCC, 1'b0, 1'b0);
                    end else if (r < 35) begin
                        drive(1'b0, 1'b0, 16'h0, phase == P_CCC, phase == P_DDR, 1'b1, 1'b0);
                    end else if (r < 45) begin
                        drive(1'b0, 1'b0, 16'h0, phase == P_CCC, phase == P_DDR, 1'b0, 1'b1);
                    end else begin
                        drive(1'b0, 1'b0, 16'h0, phase == P_CCC, phase == P_DDR, 1'b0, 1'b0);
                    end
                end
                default: begin
                    if (r < 50) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
                    else        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
                end
            endcase
        end
        if (phase != P_IDLE) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
    endtask

    initial begin
        rst                = 1'b1;
        bus.i_engine_en    = 1'b1;
        bus.i_rx_mode_done = 1'b0;
        bus.i_rx_cmd_word  = '0;
        bus.i_rx_error     = 1'b0;
        bus.i_ccc_done     = 1'b0;
        bus.i_ddr_done     = 1'b0;
        bus.i_restart_done = 1'b0;
        bus.i_exit_done    = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        // Reset with engine_en held high: all zero, no session starts
        do_reset();
        idle(5);

        // CCC frame, handler done, then Exit
        start_session();
        pre(1'b0);
        cmd(mk_cmd(1'b0, 7'h10, 7'h7E, 1'b1), 1'b0);
        idle(4);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);

        // Private read to own address, Restart mid-transfer, second frame
        start_session();
        pre(1'b0);
        cmd(mk_cmd(1'b1, 7'h25, 7'h52, 1'b1), 1'b0);
        idle(5);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        pre(1'b0);
        cmd(mk_cmd(1'b0, 7'h33, 7'h52, 1'b1), 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Bad parity: error pulse, parked until Exit
        start_session();
        pre(1'b0);
        cmd(mk_cmd(1'b0, 7'h05, 7'h7E, 1'b0), 1'b0);
        idle(6);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Silent DDR handler: watchdog abort
        start_session();
        pre(1'b0);
        cmd(mk_cmd(1'b0, 7'h01, 7'h52, 1'b1), 1'b0);
        wait_timeout();
        idle(2);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Exit coincident with CCC done: Exit wins, no error
        start_session();
        pre(1'b0);
        cmd(mk_cmd(1'b1, 7'h7F, 7'h7E, 1'b1), 1'b0);
        idle(3);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Foreign address: no enable, no error
        start_session();
        pre(1'b0);
        cmd(mk_cmd(1'b0, 7'h44, 7'h11, 1'b1), 1'b0);
        idle(4);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Reset while the CCC handler is enabled, engine_en still high
        start_session();
        pre(1'b0);
        cmd(mk_cmd(1'b1, 7'h2A, 7'h7E, 1'b1), 1'b0);
        idle(2);
        do_reset();
        idle(8);

        for (int s = 0; s < 40; s++) rand_session();

        idle(6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hdr_tgt_engine_sched.md
Name: hdr_tgt_engine_sched

Overview:
Top-level sequencer for the target-side HDR-DDR engine. After the main controller hands over HDR mode, it drives the RX path through preamble and command-word reception. It then decodes the command word and dispatches the frame to either the CCC handler (broadcast address 7'h7E) or the private DDR read/write handler (own address). It supervises handler completion, HDR Restart and HDR Exit, and returns control with a done pulse.

Parameters:
TGT_ADDR, 7'h52, this target's dynamic address compared against the command word.
TIMEOUT_CYC, 1024, maximum cycles a dispatched handler may run before abort.
CNT_W, 11, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge.
i_sys_rst  in  1  synchronous, active-high reset.
i_engine_en  in  1  level; high while the main controller grants HDR mode.
i_rx_mode_done  in  1  1-cycle pulse; current RX mode finished.
i_rx_cmd_word  in  16  deserialized command word; valid with i_rx_mode_done in CMD state.
i_rx_error  in  1  1-cycle pulse; preamble or parity error from RX, qualified by i_rx_mode_done.
i_ccc_done  in  1  1-cycle pulse from CCC handler.
i_ddr_done  in  1  1-cycle pulse from private DDR handler.
i_restart_done  in  1  1-cycle pulse; HDR Restart detected on bus.
i_exit_done  in  1  1-cycle pulse; HDR Exit detected on bus.
o_rx_en  out  1  RX deserializer enable.
o_rx_mode  out  3  3'd0 preamble, 3'd1 command word; other codes unused, driven 0.
o_ccc_en  out  1  level enable to CCC handler.
o_ddr_en  out  1  level enable to DDR handler.
o_RnW  out  1  registered cmd[15], held for the frame.
o_cmd_code  out  7  registered cmd[14:8], held for the frame.
o_engine_done  out  1  1-cycle pulse; HDR session ended.
o_err  out  1  1-cycle pulse on parity error or watchdog timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Reset in any state takes effect at the next edge, overriding all other inputs.
- States: IDLE, PRE, CMD, DISP, CCC, DDR, SKIP, DONE.
- IDLE: outputs low. Go to PRE when i_engine_en=1.
- PRE: o_rx_en=1, o_rx_mode=0.
  - i_rx_mode_done & !i_rx_error -> CMD.
  - i_rx_mode_done & i_rx_error -> SKIP.
- CMD: o_rx_en=1, o_rx_mode=1.
  - On i_rx_mode_done, latch o_RnW/o_cmd_code and the address field cmd[7:1].
  - Parity: bit0 must equal ~^cmd[15:1] (odd parity).
  - Parity or i_rx_error fail -> SKIP with o_err pulse; otherwise -> DISP.
- DISP (1 cycle, o_rx_en=0):
  - addr=7'h7E -> CCC.
  - addr=TGT_ADDR -> DDR.
  - Otherwise -> SKIP (no error).
- CCC/DDR: the matching enable is high, the other low; watchdog counts from 0.
  - Matching done pulse -> SKIP (wait for bus Restart/Exit).
  - Counter reaches TIMEOUT_CYC-1 -> SKIP with o_err pulse.
  - The counter saturates and clears on state exit.
  - Done from the non-selected handler is ignored.
- SKIP: all enables low; the block only waits.
- Restart/Exit in any state except IDLE/DONE:
  - i_exit_done -> DONE.
  - Else i_restart_done -> PRE; the counter clears and o_RnW/o_cmd_code are held until the next latch.
  - Priority when coincident: i_exit_done > i_restart_done > handler done/timeout > RX events.
- Enables fall in the same cycle the transition is registered: Restart/Exit in CCC/DDR drops o_ccc_en/o_ddr_en on the next edge.
- DONE: o_engine_done=1 for exactly 1 cycle, then IDLE. IDLE re-arms only after i_engine_en is seen low-then-high; a level held high does not start a second session.
- i_engine_en dropping mid-session: ignored; only Exit or reset ends a session.
- Latency: command-word done -> handler enable high = 2 cycles (CMD->DISP->CCC/DDR).
- o_err and o_engine_done never assert in the same cycle.

Test Plan:
- Reset while in CCC with o_ccc_en=1 -> next cycle all outputs 0, state IDLE; engine_en still high does not restart.
- engine_en=1, preamble ok, cmd 16'h7_? with addr 7'h7E, valid parity -> o_ccc_en=1 two cycles after cmd done. Then ccc_done, exit_done -> o_engine_done one-cycle pulse.
- Cmd addr=7'h52, RnW=1, code 7'h25 -> o_ddr_en=1, o_RnW=1, o_cmd_code=7'h25. restart_done mid-transfer -> o_ddr_en=0 next edge, o_rx_mode=0.
- Cmd with flipped parity bit -> o_err pulse, no enable asserted, state SKIP until exit_done.
- DDR dispatched, no ddr_done for 1024 cycles -> o_ddr_en falls, o_err pulses at cycle 1024.
- exit_done and ccc_done in the same cycle -> DONE taken, o_engine_done pulse, no o_err; addr 7'h11 -> SKIP, no enables, no error.
